// File: rtl/trim_pkg.sv
// Shared types and helpers for the BPM gain-trim blocks: FSM states, unity gain, round-half-up.
// Pure declarations; no latency, no backpressure.
package trim_pkg;

   localparam int NUM_CH = 4;
   localparam int MAX_W  = 64;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN,
      DONE
   } state_t;

   // Unity for a gain with the binary point just below the MSB.
   function automatic logic [MAX_W-1:0] unity_gain(input int gain_width);
      unity_gain = {{(MAX_W-1){1'b0}}, 1'b1} << (gain_width - 1);
   endfunction

   // Returns field + half with one extra bit so callers can see the carry-out.
   function automatic logic [MAX_W:0] round_half_up(input logic [MAX_W-1:0] field,
                                                    input logic             half);
      round_half_up = {1'b0, field} + {{MAX_W{1'b0}}, half};
   endfunction

endpackage

// File: rtl/trim_mult_pipe.sv
// LAT-stage unsigned multiplier carrying a valid bit and channel tag with the data.
// Latency LAT cycles, one issue per cycle, no backpressure.
module trim_mult_pipe #(
   parameter int A_W   = 26,
   parameter int B_W   = 27,
   parameter int LAT   = 6,
   parameter int TAG_W = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 issue_vld,
   input  logic [TAG_W-1:0]     issue_tag,
   input  logic [A_W-1:0]       a_dat,
   input  logic [B_W-1:0]       b_dat,
   output logic                 res_vld,
   output logic [TAG_W-1:0]     res_tag,
   output logic [A_W+B_W-1:0]   res_dat
);

   localparam int PW = A_W + B_W;

   logic [LAT-1:0]            vld_q;
   logic [LAT-1:0][TAG_W-1:0] tag_q;
   logic [LAT-1:0][PW-1:0]    dat_q;
   logic [PW-1:0]             prod_c;

   // Stages after the first give synthesis room to retime the multiplier.
   assign prod_c = {{B_W{1'b0}}, a_dat} * {{A_W{1'b0}}, b_dat};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
      end else begin
         vld_q[0] <= issue_vld;
         for (int i = 1; i < LAT; i++) begin
            vld_q[i] <= vld_q[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      dat_q[0] <= prod_c;
      tag_q[0] <= issue_tag;
      for (int i = 1; i < LAT; i++) begin
         dat_q[i] <= dat_q[i-1];
         tag_q[i] <= tag_q[i-1];
      end
   end

   assign res_vld = vld_q[LAT-1];
   assign res_tag = tag_q[LAT-1];
   assign res_dat = dat_q[LAT-1];

endmodule

// File: rtl/trim_serial_sequencer.sv
// Serial gain trim of four magnitudes through one shared multiplier; result at strobe+MULT_LATENCY+5.
// Strobes arriving while busy are dropped and counted; TRIM_SERIAL_SATURATE_EN adds saturation and sat_flag.
module trim_serial_sequencer
   import trim_pkg::*;
#(
   parameter int MAG_WIDTH    = 26,
   parameter int GAIN_WIDTH   = 27,
   parameter int MULT_LATENCY = 6,
   parameter int OVR_WIDTH    = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          strobe,
   input  logic [NUM_CH*MAG_WIDTH-1:0]   magnitudes,
   input  logic                          gain_wr,
   input  logic [1:0]                    gain_addr,
   input  logic [GAIN_WIDTH-1:0]         gain_data,
   input  logic                          gain_commit,
   output logic                          busy,
   output logic                          commit_pending,
   output logic [OVR_WIDTH-1:0]          overrun_count,
   output logic                          trimmedToggle,
`ifdef TRIM_SERIAL_SATURATE_EN
   output logic                          sat_flag,
`endif
   output logic [NUM_CH*MAG_WIDTH-1:0]   trimmed
);

   localparam int PW = MAG_WIDTH + GAIN_WIDTH;
   localparam logic [MAX_W-1:0]      UNITY_FULL = unity_gain(GAIN_WIDTH);
   localparam logic [GAIN_WIDTH-1:0] UNITY      = UNITY_FULL[GAIN_WIDTH-1:0];

   state_t state, state_nxt;
   logic   start, done_cyc, issue_vld;
   logic [1:0] ch;

   logic [NUM_CH-1:0][MAG_WIDTH-1:0]  snap, shadow;
   logic [NUM_CH-1:0][GAIN_WIDTH-1:0] staging, staging_nxt, active;

   logic                 res_vld;
   logic [1:0]           res_tag;
   logic [PW-1:0]        res_dat;
   logic [MAG_WIDTH-1:0] field;
   logic                 half;
   logic [MAX_W:0]       rsum;
   logic [MAG_WIDTH-1:0] lane_res;
   logic                 unused_bits;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      done_cyc  = 1'b0;
      issue_vld = 1'b0;
      case (state)
         IDLE: begin
            if (strobe) begin
               start     = 1'b1;
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            issue_vld = 1'b1;
            if (ch == 2'(NUM_CH-1)) state_nxt = DRAIN;
         end
         DRAIN: begin
            if (res_vld && res_tag == 2'(NUM_CH-1)) state_nxt = DONE;
         end
         DONE: begin
            done_cyc  = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ch   <= '0;
         snap <= '0;
      end else if (start) begin
         ch   <= '0;
         snap <= magnitudes;
      end else if (state == ISSUE) begin
         ch   <= ch + 2'd1;
      end
   end

   always_comb begin
      staging_nxt = staging;
      if (gain_wr) staging_nxt[gain_addr] = gain_data;
   end

   // Active gains only move when no set is in flight, so a set never mixes gain generations.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         staging        <= {NUM_CH{UNITY}};
         active         <= {NUM_CH{UNITY}};
         commit_pending <= 1'b0;
      end else begin
         staging <= staging_nxt;
         if (done_cyc) begin
            if (commit_pending || gain_commit) active <= staging_nxt;
            commit_pending <= 1'b0;
         end else if (gain_commit) begin
            if (state == IDLE && !strobe) active <= staging_nxt;
            else                          commit_pending <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                          overrun_count <= '0;
      else if (strobe && busy && overrun_count != '1)      overrun_count <= overrun_count + 1'b1;
   end

   trim_mult_pipe #(
      .A_W   (MAG_WIDTH),
      .B_W   (GAIN_WIDTH),
      .LAT   (MULT_LATENCY),
      .TAG_W (2)
   ) u_mult (
      .clk       (clk),
      .rst_n     (rst_n),
      .issue_vld (issue_vld),
      .issue_tag (ch),
      .a_dat     (snap[ch]),
      .b_dat     (active[ch]),
      .res_vld   (res_vld),
      .res_tag   (res_tag),
      .res_dat   (res_dat)
   );

   assign field = res_dat[GAIN_WIDTH-1 +: MAG_WIDTH];
   assign half  = res_dat[GAIN_WIDTH-2];
   assign rsum  = round_half_up({{(MAX_W-MAG_WIDTH){1'b0}}, field}, half);

`ifdef TRIM_SERIAL_SATURATE_EN
   logic hi_ovf, lane_sat;
   assign hi_ovf      = |res_dat[PW-1:GAIN_WIDTH-1+MAG_WIDTH];
   assign lane_sat    = hi_ovf | rsum[MAG_WIDTH];
   assign lane_res    = lane_sat ? '1 : rsum[MAG_WIDTH-1:0];
   assign unused_bits = ^{res_dat[GAIN_WIDTH-3:0], rsum[MAX_W:MAG_WIDTH+1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                    sat_flag <= 1'b0;
      else if (res_vld && lane_sat)  sat_flag <= 1'b1;
   end
`else
   assign lane_res    = rsum[MAG_WIDTH-1:0];
   assign unused_bits = ^{res_dat[PW-1:GAIN_WIDTH-1+MAG_WIDTH], res_dat[GAIN_WIDTH-3:0],
                          rsum[MAX_W:MAG_WIDTH]};
`endif

   // Lanes fill the shadow one by one; trimmed only ever sees a complete set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow        <= '0;
         trimmed       <= '0;
         trimmedToggle <= 1'b0;
      end else begin
         if (res_vld) shadow[res_tag] <= lane_res;
         if (done_cyc) begin
            trimmed       <= shadow;
            trimmedToggle <= ~trimmedToggle;
         end
      end
   end

endmodule
